// File: rtl/odd_parity_pkg.sv
// Shared types and helpers for the odd-parity serial receiver.
//   state_t          receiver FSM states
//   DATA_W_DEF       default data bits per frame
//   CLKS_PER_BIT_DEF default clk cycles per bit period
//   odd_par()        parity bit that makes the total count of ones odd
package odd_parity_pkg;

  localparam int DATA_W_DEF       = 4;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Zero-extended inputs are safe here: padding zeros never change parity.
  function automatic logic odd_par(input logic [31:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/odd_parity_rx_bit_sync2.sv
// Two-flop synchroniser for a single asynchronous bit.
//   clk   rising-edge clock
//   rst_n synchronous active-low reset (both flops reset to 1, the idle level)
//   d     asynchronous input
//   q     synchronised output
module bit_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/odd_parity_rx.sv
// Odd-parity serial frame receiver.
// Frame: start(0), DATA_W data bits LSB first, odd parity bit, stop(1).
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   rx_in      asynchronous serial line, idles high
//   data_out   last received data word (held until next completed frame)
//   data_valid one-cycle pulse when a frame completes
//   parity_err parity check failed, qualified by data_valid
//   frame_err  stop bit sampled low, qualified by data_valid
//   busy       high whenever the FSM is outside IDLE
module odd_parity_rx
  import odd_parity_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W + 1);

  state_t            state, state_nx;
  logic              rxs;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shreg;
  logic              pbit;
  logic              armed;
  logic              mid_tick, bit_tick, last_bit;

  bit_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rxs)
  );

  // Start bit is checked half a period in; every later bit one full period on,
  // which lands each sample near the middle of its bit.
  assign mid_tick = (cnt == CW'(CLKS_PER_BIT/2 - 1));
  assign bit_tick = (cnt == CW'(CLKS_PER_BIT - 1));
  assign last_bit = (idx == IW'(DATA_W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (armed && !rxs)        state_nx = START;
      START:   if (mid_tick)             state_nx = rxs ? IDLE : DATA;
      DATA:    if (bit_tick && last_bit) state_nx = PARITY;
      PARITY:  if (bit_tick)             state_nx = STOP;
      STOP:    if (bit_tick)             state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: bit counter, shift register and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      pbit       <= 1'b0;
      armed      <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (rxs) armed <= 1'b1;
        end
        START: begin
          cnt <= mid_tick ? '0 : cnt + CW'(1);
        end
        DATA: begin
          cnt <= bit_tick ? '0 : cnt + CW'(1);
          if (bit_tick) begin
            // LSB arrives first, so shift in from the top.
            shreg <= {rxs, shreg[DATA_W-1:1]};
            idx   <= idx + IW'(1);
          end
        end
        PARITY: begin
          cnt <= bit_tick ? '0 : cnt + CW'(1);
          if (bit_tick) pbit <= rxs;
        end
        STOP: begin
          cnt <= bit_tick ? '0 : cnt + CW'(1);
          if (bit_tick) begin
            data_out   <= shreg;
            parity_err <= odd_par(32'(shreg)) ^ pbit;
            frame_err  <= ~rxs;
            data_valid <= 1'b1;
            // A break (low stop bit) must see the line high before re-arming.
            armed      <= rxs;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_odd_parity_rx.sv
module tb_odd_parity_rx;

  localparam int DW  = 4;
  localparam int CPB = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_in = 1'b1;
  logic [DW-1:0] data_out;
  logic          data_valid, parity_err, frame_err, busy;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   pulses = 0;
  int   last_pulse_cyc = 0;
  int   prev_pulse_cyc = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  odd_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a frame.
  always @(negedge clk) begin
    if (data_valid) begin
      exp_t e;
      pulses++;
      prev_pulse_cyc = last_pulse_cyc;
      last_pulse_cyc = cyc;
      check("valid_one_cycle", int'(prev_valid), 0);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid got=data %0h exp=no pulse", data_out);
      end else begin
        e = sb.pop_front();
        total--;
        check("data_out", int'(data_out), int'(e.d));
        check("parity_err", int'(parity_err), int'(e.pe));
        check("frame_err", int'(frame_err), int'(e.fe));
      end
    end
    prev_valid = data_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stop);
    logic [DW+2:0] bits;
    bits = {stop, p, d, 1'b0};
    for (int i = 0; i < DW + 3; i++) begin
      rx_in = bits[i];
      idle(CPB);
    end
  endtask

  int t0, n0;

  initial begin
    // Reset state
    idle(4);
    check("rst_data_out", int'(data_out), 0);
    check("rst_valid", int'(data_valid), 0);
    check("rst_parity_err", int'(parity_err), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle(5);

    // 0xA, correct parity 1: latency check
    sb.push_back('{d: 4'hA, pe: 1'b0, fe: 1'b0});
    t0 = cyc;
    send_frame(4'hA, 1'b1, 1'b1);
    check("a_pulses", pulses, 1);
    check("a_latency_ok", int'((last_pulse_cyc - t0) >= 105 && (last_pulse_cyc - t0) <= 107), 1);
    idle(5);

    // 0x7 with wrong parity bit 1 (correct odd parity bit is 0)
    sb.push_back('{d: 4'h7, pe: 1'b1, fe: 1'b0});
    send_frame(4'h7, 1'b1, 1'b1);
    idle(5);

    // 0x7 with correct parity bit 0
    sb.push_back('{d: 4'h7, pe: 1'b0, fe: 1'b0});
    send_frame(4'h7, 1'b0, 1'b1);
    idle(5);

    // Glitch: 3 low cycles is a false start
    n0 = pulses;
    rx_in = 1'b0;
    idle(3);
    rx_in = 1'b1;
    idle(2);
    check("glitch_busy_high", int'(busy), 1);
    idle(20);
    check("glitch_busy_low", int'(busy), 0);
    check("glitch_no_pulse", pulses, n0);
    check("glitch_data_held", int'(data_out), 7);
    check("glitch_flags_held", int'({parity_err, frame_err}), 0);

    // Break: 0x0, parity 1, stop 0, then line low 50 cycles
    sb.push_back('{d: 4'h0, pe: 1'b0, fe: 1'b1});
    send_frame(4'h0, 1'b1, 1'b0);
    n0 = pulses;
    idle(25);
    check("break_not_busy_mid", int'(busy), 0);
    idle(25);
    check("break_not_busy_end", int'(busy), 0);
    check("break_no_retrigger", pulses, n0);
    rx_in = 1'b1;
    idle(20);
    check("break_recover_idle", int'(busy), 0);

    // Back-to-back 0x1 then 0xE
    sb.push_back('{d: 4'h1, pe: 1'b0, fe: 1'b0});
    sb.push_back('{d: 4'hE, pe: 1'b0, fe: 1'b0});
    send_frame(4'h1, 1'b0, 1'b1);
    send_frame(4'hE, 1'b0, 1'b1);
    idle(5);
    check("b2b_spacing", last_pulse_cyc - prev_pulse_cyc, (DW + 3) * CPB);

    // Reset at cycle 40 of a 0x5 frame, then a full 0x3 frame
    n0 = pulses;
    begin
      logic [DW+2:0] bits;
      bits = {1'b1, 1'b1, 4'h5, 1'b0};
      for (int i = 0; i < 40; i++) begin
        rx_in = bits[i / CPB];
        @(negedge clk);
      end
    end
    rst_n = 1'b0;
    rx_in = 1'b1;
    idle(2);
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle(20);
    sb.push_back('{d: 4'h3, pe: 1'b0, fe: 1'b0});
    send_frame(4'h3, 1'b1, 1'b1);
    idle(10);
    check("midrst_one_pulse", pulses - n0, 1);

    idle(20);
    check("sb_drained", sb.size(), 0);
    check("total_pulses", pulses, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
